// File: rtl/mem_stage_pkg.sv
// Shared widths, byte-lane constants and access-format helpers for the MEM stage.
package mem_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int PC_W       = 32;
  localparam int REG_W      = 5;
  localparam int MEM_ADDR_W = 7;

  localparam int BYTE_W     = 8;
  localparam int BYTE_LANES = DATA_W / BYTE_W;

  localparam logic [1:0] OFF_LANE0   = 2'd0;
  localparam logic [1:0] OFF_HALF_HI = 2'd2;

  typedef enum logic [1:0] {
    FMT_BYTE,
    FMT_HALF,
    FMT_WORD
  } load_fmt_e;

  function automatic load_fmt_e access_fmt(input logic byte_en, input logic half_en);
    if (byte_en) return FMT_BYTE;
    if (half_en) return FMT_HALF;
    return FMT_WORD;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Byte-lane writable data memory with an asynchronous access port and debug port.
module mem_stage_data_memory
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = DATA_W,
  parameter int NB_ADDR = MEM_ADDR_W
) (
  input  logic                    i_clock,
  input  logic [NB_DATA/8-1:0]    i_lane_we,
  input  logic [NB_ADDR-1:0]      i_addr,
  input  logic [NB_DATA-1:0]      i_wdata,
  output logic [NB_DATA-1:0]      o_rdata,
  input  logic [NB_ADDR-1:0]      i_debug_addr,
  output logic [NB_DATA-1:0]      o_debug_data
);

  localparam int NB_LANES = NB_DATA / 8;

  logic [NB_DATA-1:0] mem_q [0:(2**NB_ADDR)-1];

  // NOTE: storage has no reset; clearing it would turn the RAM into flops.
  always_ff @(posedge i_clock) begin
    for (int lane = 0; lane < NB_LANES; lane++) begin
      if (i_lane_we[lane]) begin
        mem_q[i_addr][lane*8 +: 8] <= i_wdata[lane*8 +: 8];
      end
    end
  end

  assign o_rdata      = mem_q[i_addr];
  assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data memory, load formatter, branch and halt.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA     = DATA_W,
  parameter int NB_PC       = PC_W,
  parameter int NB_REG      = REG_W,
  parameter int NB_MEM_ADDR = MEM_ADDR_W
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_MEM_enable,
  input  logic                   i_MEM_signed,
  input  logic                   i_MEM_reg_write,
  input  logic                   i_MEM_mem_to_reg,
  input  logic                   i_MEM_mem_read,
  input  logic                   i_MEM_mem_write,
  input  logic                   i_MEM_branch,
  input  logic                   i_MEM_zero,
  input  logic                   i_MEM_byte_en,
  input  logic                   i_MEM_halfword_en,
  input  logic                   i_MEM_word_en,
  input  logic                   i_MEM_r31_ctrl,
  input  logic                   i_MEM_hlt,
  input  logic [NB_PC-1:0]       i_MEM_branch_addr,
  input  logic [NB_DATA-1:0]     i_MEM_alu_result,
  input  logic [NB_DATA-1:0]     i_MEM_data_b,
  input  logic [NB_REG-1:0]      i_MEM_selected_reg,
  input  logic [NB_PC-1:0]       i_MEM_pc,
  input  logic [NB_MEM_ADDR-1:0] i_MEM_debug_addr,
  output logic                   o_MEM_pc_src,
  output logic [NB_PC-1:0]       o_MEM_branch_addr,
  output logic [NB_DATA-1:0]     o_MEM_fwd_data,
  output logic [NB_DATA-1:0]     o_MEM_read_data,
  output logic [NB_DATA-1:0]     o_MEM_alu_result,
  output logic [NB_PC-1:0]       o_MEM_pc,
  output logic [NB_REG-1:0]      o_MEM_selected_reg,
  output logic                   o_MEM_reg_write,
  output logic                   o_MEM_mem_to_reg,
  output logic                   o_MEM_r31_ctrl,
  output logic                   o_MEM_misaligned,
  output logic                   o_MEM_halted,
  output logic [NB_DATA-1:0]     o_MEM_debug_data
);

  localparam int NB_LANES = NB_DATA / BYTE_W;

  logic signed_q, reg_write_q, mem_to_reg_q, mem_read_q, mem_write_q;
  logic branch_q, zero_q, byte_en_q, half_en_q, word_en_q, r31_ctrl_q;
  logic halted_q, halted_d;
  logic [NB_PC-1:0]   branch_addr_q, pc_q;
  logic [NB_DATA-1:0] alu_result_q, data_b_q;
  logic [NB_REG-1:0]  selected_reg_q;

  logic capture;
  assign capture  = i_MEM_enable & ~halted_q;
  assign halted_d = halted_q | (capture & i_MEM_hlt);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      signed_q       <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      branch_q       <= 1'b0;
      zero_q         <= 1'b0;
      byte_en_q      <= 1'b0;
      half_en_q      <= 1'b0;
      word_en_q      <= 1'b0;
      r31_ctrl_q     <= 1'b0;
      halted_q       <= 1'b0;
      branch_addr_q  <= '0;
      pc_q           <= '0;
      alu_result_q   <= '0;
      data_b_q       <= '0;
      selected_reg_q <= '0;
    end else begin
      halted_q <= halted_d;
      if (capture) begin
        signed_q       <= i_MEM_signed;
        reg_write_q    <= i_MEM_reg_write;
        mem_to_reg_q   <= i_MEM_mem_to_reg;
        mem_read_q     <= i_MEM_mem_read;
        mem_write_q    <= i_MEM_mem_write;
        branch_q       <= i_MEM_branch;
        zero_q         <= i_MEM_zero;
        byte_en_q      <= i_MEM_byte_en;
        half_en_q      <= i_MEM_halfword_en;
        word_en_q      <= i_MEM_word_en;
        r31_ctrl_q     <= i_MEM_r31_ctrl;
        branch_addr_q  <= i_MEM_branch_addr;
        pc_q           <= i_MEM_pc;
        alu_result_q   <= i_MEM_alu_result;
        data_b_q       <= i_MEM_data_b;
        selected_reg_q <= i_MEM_selected_reg;
      end
    end
  end

  logic [1:0]             off;
  logic [NB_MEM_ADDR-1:0] word_addr;
  load_fmt_e              fmt;
  logic                   misaligned;
  logic                   store_ok;

  assign off        = alu_result_q[1:0];
  assign word_addr  = alu_result_q[NB_MEM_ADDR+1:2];
  assign fmt        = access_fmt(byte_en_q, half_en_q);
  assign misaligned = ((half_en_q & off[0]) | (word_en_q & (off != OFF_LANE0)))
                    & (mem_read_q | mem_write_q);
  // Gating with i_reset drops a store whose edge lands while reset is held.
  assign store_ok   = mem_write_q & ~misaligned & capture & i_reset;

  logic [NB_LANES-1:0] lane_we;
  logic [NB_DATA-1:0]  wdata;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lane_we = '0;
    wdata   = data_b_q;
    unique case (fmt)
      FMT_BYTE: begin
        lane_we = NB_LANES'(1) << off;
        wdata   = {NB_LANES{data_b_q[7:0]}};
      end
      FMT_HALF: begin
        lane_we = (off[1] == OFF_HALF_HI[1]) ? NB_LANES'(4'b1100) : NB_LANES'(4'b0011);
        wdata   = {(NB_LANES/2){data_b_q[15:0]}};
      end
      default: lane_we = '1;
    endcase
    if (!store_ok) lane_we = '0;
  end

  logic [NB_DATA-1:0] rdata, dbg_rdata;

  mem_stage_data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_MEM_ADDR)
  ) u_data_memory (
    .i_clock      (i_clock),
    .i_lane_we    (lane_we),
    .i_addr       (word_addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .i_debug_addr (i_MEM_debug_addr),
    .o_debug_data (dbg_rdata)
  );

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte         = rdata[{off, 3'b000} +: 8];
    rd_half         = off[1] ? rdata[31:16] : rdata[15:0];
    o_MEM_read_data = '0;
    if (mem_read_q && !misaligned) begin
      unique case (fmt)
        FMT_BYTE: o_MEM_read_data = {{(NB_DATA-8){signed_q & rd_byte[7]}}, rd_byte};
        FMT_HALF: o_MEM_read_data = {{(NB_DATA-16){signed_q & rd_half[15]}}, rd_half};
        default:  o_MEM_read_data = rdata;
      endcase
    end
  end

  assign o_MEM_pc_src       = branch_q & zero_q;
  assign o_MEM_branch_addr  = branch_addr_q;
  assign o_MEM_fwd_data     = alu_result_q;
  assign o_MEM_alu_result   = alu_result_q;
  assign o_MEM_pc           = pc_q;
  assign o_MEM_selected_reg = selected_reg_q;
  assign o_MEM_reg_write    = reg_write_q;
  assign o_MEM_mem_to_reg   = mem_to_reg_q;
  assign o_MEM_r31_ctrl     = r31_ctrl_q;
  assign o_MEM_misaligned   = misaligned;
  assign o_MEM_halted       = halted_q;
  // The debug port is forced to zero during reset so every output reads 0 then.
  assign o_MEM_debug_data   = i_reset ? dbg_rdata : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, multi-cycle corner cases, random vs model.
module tb_mem_stage;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_MEM_enable, i_MEM_signed, i_MEM_reg_write, i_MEM_mem_to_reg;
  logic        i_MEM_mem_read, i_MEM_mem_write, i_MEM_branch, i_MEM_zero;
  logic        i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en, i_MEM_r31_ctrl, i_MEM_hlt;
  logic [31:0] i_MEM_branch_addr, i_MEM_alu_result, i_MEM_data_b, i_MEM_pc;
  logic [4:0]  i_MEM_selected_reg;
  logic [6:0]  i_MEM_debug_addr;
  logic        o_MEM_pc_src, o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl;
  logic        o_MEM_misaligned, o_MEM_halted;
  logic [31:0] o_MEM_branch_addr, o_MEM_fwd_data, o_MEM_read_data, o_MEM_alu_result;
  logic [31:0] o_MEM_pc, o_MEM_debug_data;
  logic [4:0]  o_MEM_selected_reg;

  mem_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_MEM_enable(i_MEM_enable),
    .i_MEM_signed(i_MEM_signed), .i_MEM_reg_write(i_MEM_reg_write),
    .i_MEM_mem_to_reg(i_MEM_mem_to_reg), .i_MEM_mem_read(i_MEM_mem_read),
    .i_MEM_mem_write(i_MEM_mem_write), .i_MEM_branch(i_MEM_branch), .i_MEM_zero(i_MEM_zero),
    .i_MEM_byte_en(i_MEM_byte_en), .i_MEM_halfword_en(i_MEM_halfword_en),
    .i_MEM_word_en(i_MEM_word_en), .i_MEM_r31_ctrl(i_MEM_r31_ctrl), .i_MEM_hlt(i_MEM_hlt),
    .i_MEM_branch_addr(i_MEM_branch_addr), .i_MEM_alu_result(i_MEM_alu_result),
    .i_MEM_data_b(i_MEM_data_b), .i_MEM_selected_reg(i_MEM_selected_reg),
    .i_MEM_pc(i_MEM_pc), .i_MEM_debug_addr(i_MEM_debug_addr),
    .o_MEM_pc_src(o_MEM_pc_src), .o_MEM_branch_addr(o_MEM_branch_addr),
    .o_MEM_fwd_data(o_MEM_fwd_data), .o_MEM_read_data(o_MEM_read_data),
    .o_MEM_alu_result(o_MEM_alu_result), .o_MEM_pc(o_MEM_pc),
    .o_MEM_selected_reg(o_MEM_selected_reg), .o_MEM_reg_write(o_MEM_reg_write),
    .o_MEM_mem_to_reg(o_MEM_mem_to_reg), .o_MEM_r31_ctrl(o_MEM_r31_ctrl),
    .o_MEM_misaligned(o_MEM_misaligned), .o_MEM_halted(o_MEM_halted),
    .o_MEM_debug_data(o_MEM_debug_data)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic        rd, wr, sgn, be, he, we, br, zr, rw, m2r, r31, hlt;
    logic [31:0] alu, db, baddr, pc;
    logic [4:0]  sel;
  } instr_t;

  typedef struct {
    string       name;
    instr_t      ins;
    logic [6:0]  dbg;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_pcsrc;
    logic [31:0] exp_baddr;
    logic [31:0] exp_dbg;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: byte-addressed memory, the last captured instruction and the halt flag.
  logic [7:0] mem_m [0:511];
  instr_t     cap;
  bit         halted_m;
  instr_t     cur;
  logic       cur_en;
  logic [6:0] cur_dbg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic instr_t with_size(input instr_t r, input int sz);
    instr_t o;
    o    = r;
    o.be = (sz == 1);
    o.he = (sz == 2);
    o.we = (sz == 4);
    return o;
  endfunction

  function automatic instr_t st(input logic [31:0] a, input int sz, input logic [31:0] d);
    instr_t r;
    r     = nop();
    r.wr  = 1'b1;
    r.alu = a;
    r.db  = d;
    return with_size(r, sz);
  endfunction

  function automatic instr_t ld(input logic [31:0] a, input int sz, input logic s);
    instr_t r;
    r     = nop();
    r.rd  = 1'b1;
    r.sgn = s;
    r.alu = a;
    return with_size(r, sz);
  endfunction

  function automatic int m_size(input instr_t r);
    if (r.be) return 1;
    if (r.he) return 2;
    return 4;
  endfunction

  function automatic int m_addr(input instr_t r);
    return int'(r.alu % 32'd512);
  endfunction

  function automatic logic m_mis(input instr_t r);
    return (r.rd || r.wr) && (m_addr(r) % m_size(r) != 0);
  endfunction

  function automatic logic [31:0] m_word(input int w);
    return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
  endfunction

  function automatic logic [31:0] m_load(input instr_t r);
    longint v;
    int     sz;
    v  = 0;
    sz = m_size(r);
    if (!r.rd || m_mis(r)) return 32'h0;
    for (int k = 0; k < sz; k++) v += longint'(mem_m[m_addr(r) + k]) << (8 * k);
    if (r.sgn && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic model_reset();
    cap      = nop();
    halted_m = 1'b0;
  endtask

  task automatic model_edge();
    if (i_reset && cur_en && !halted_m) begin
      if (cap.wr && !m_mis(cap)) begin
        for (int k = 0; k < m_size(cap); k++) mem_m[m_addr(cap) + k] = 8'((cap.db >> (8 * k)) & 32'hFF);
      end
      cap = cur;
      if (cur.hlt) halted_m = 1'b1;
    end
  endtask

  task automatic drive(input instr_t r, input logic en, input logic [6:0] dbg);
    cur = r; cur_en = en; cur_dbg = dbg;
    i_MEM_enable = en;        i_MEM_signed = r.sgn;       i_MEM_reg_write = r.rw;
    i_MEM_mem_to_reg = r.m2r; i_MEM_mem_read = r.rd;      i_MEM_mem_write = r.wr;
    i_MEM_branch = r.br;      i_MEM_zero = r.zr;          i_MEM_byte_en = r.be;
    i_MEM_halfword_en = r.he; i_MEM_word_en = r.we;       i_MEM_r31_ctrl = r.r31;
    i_MEM_hlt = r.hlt;        i_MEM_branch_addr = r.baddr; i_MEM_alu_result = r.alu;
    i_MEM_data_b = r.db;      i_MEM_selected_reg = r.sel; i_MEM_pc = r.pc;
    i_MEM_debug_addr = dbg;
  endtask

  task automatic tick();
    @(posedge i_clock);
    model_edge();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc_src"},   32'(o_MEM_pc_src), 32'h0);
    check({tag, ".baddr"},    o_MEM_branch_addr, 32'h0);
    check({tag, ".fwd"},      o_MEM_fwd_data, 32'h0);
    check({tag, ".rdata"},    o_MEM_read_data, 32'h0);
    check({tag, ".alu"},      o_MEM_alu_result, 32'h0);
    check({tag, ".pc"},       o_MEM_pc, 32'h0);
    check({tag, ".sel"},      32'(o_MEM_selected_reg), 32'h0);
    check({tag, ".rw"},       32'(o_MEM_reg_write), 32'h0);
    check({tag, ".m2r"},      32'(o_MEM_mem_to_reg), 32'h0);
    check({tag, ".r31"},      32'(o_MEM_r31_ctrl), 32'h0);
    check({tag, ".mis"},      32'(o_MEM_misaligned), 32'h0);
    check({tag, ".halted"},   32'(o_MEM_halted), 32'h0);
    check({tag, ".dbg"},      o_MEM_debug_data, 32'h0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pc_src"}, 32'(o_MEM_pc_src), 32'(cap.br & cap.zr));
    check({tag, ".baddr"},  o_MEM_branch_addr, cap.baddr);
    check({tag, ".fwd"},    o_MEM_fwd_data, cap.alu);
    check({tag, ".alu"},    o_MEM_alu_result, cap.alu);
    check({tag, ".rdata"},  o_MEM_read_data, m_load(cap));
    check({tag, ".pc"},     o_MEM_pc, cap.pc);
    check({tag, ".sel"},    32'(o_MEM_selected_reg), 32'(cap.sel));
    check({tag, ".rw"},     32'(o_MEM_reg_write), 32'(cap.rw));
    check({tag, ".m2r"},    32'(o_MEM_mem_to_reg), 32'(cap.m2r));
    check({tag, ".r31"},    32'(o_MEM_r31_ctrl), 32'(cap.r31));
    check({tag, ".mis"},    32'(o_MEM_misaligned), 32'(m_mis(cap)));
    check({tag, ".halted"}, 32'(o_MEM_halted), 32'(halted_m));
    check({tag, ".dbg"},    o_MEM_debug_data, m_word(int'(cur_dbg)));
  endtask

  vec_t vecs[$];

  task automatic add_vec(input string nm, input instr_t r, input logic [6:0] dbg,
                         input logic [31:0] erd, input logic emis, input logic epc,
                         input logic [31:0] eba, input logic [31:0] edbg);
    vec_t v;
    v.name = nm; v.ins = r; v.dbg = dbg; v.exp_rd = erd; v.exp_mis = emis;
    v.exp_pcsrc = epc; v.exp_baddr = eba; v.exp_dbg = edbg;
    vecs.push_back(v);
  endtask

  initial begin
    instr_t r;
    model_reset();
    drive(nop(), 1'b0, 7'd0);

    // Directed table: memory is zero-filled before it runs.
    add_vec("sw10",   st(32'h10, 4, 32'hDEADBEEF), 7'd4, 32'h0,        0, 0, 32'h0,  32'h0);
    add_vec("lw10",   ld(32'h10, 4, 0),            7'd4, 32'hDEADBEEF, 0, 0, 32'h0,  32'hDEADBEEF);
    add_vec("sb13",   st(32'h13, 1, 32'h80),       7'd4, 32'h0,        0, 0, 32'h0,  32'hDEADBEEF);
    add_vec("lb13s",  ld(32'h13, 1, 1),            7'd4, 32'hFFFFFF80, 0, 0, 32'h0,  32'h80ADBEEF);
    add_vec("lb13u",  ld(32'h13, 1, 0),            7'd4, 32'h00000080, 0, 0, 32'h0,  32'h80ADBEEF);
    add_vec("lw10b",  ld(32'h10, 4, 0),            7'd4, 32'h80ADBEEF, 0, 0, 32'h0,  32'h80ADBEEF);
    add_vec("sh11",   st(32'h11, 2, 32'h1234),     7'd4, 32'h0,        1, 0, 32'h0,  32'h80ADBEEF);
    add_vec("lw12",   ld(32'h12, 4, 0),            7'd4, 32'h0,        1, 0, 32'h0,  32'h80ADBEEF);
    add_vec("lh12s",  ld(32'h12, 2, 1),            7'd4, 32'hFFFF80AD, 0, 0, 32'h0,  32'h80ADBEEF);
    add_vec("lh10u",  ld(32'h10, 2, 0),            7'd4, 32'h0000BEEF, 0, 0, 32'h0,  32'h80ADBEEF);
    r = nop(); r.br = 1; r.zr = 1; r.baddr = 32'h40;
    add_vec("beq_t",  r,                           7'd4, 32'h0,        0, 1, 32'h40, 32'h80ADBEEF);
    r = nop(); r.br = 1; r.zr = 0; r.baddr = 32'h44;
    add_vec("beq_nt", r,                           7'd4, 32'h0,        0, 0, 32'h44, 32'h80ADBEEF);
    add_vec("nop",    nop(),                       7'd4, 32'h0,        0, 0, 32'h0,  32'h80ADBEEF);
    add_vec("sw210",  st(32'h210, 4, 32'h0BADF00D), 7'd4, 32'h0,       0, 0, 32'h0,  32'h80ADBEEF);
    add_vec("lw10c",  ld(32'h10, 4, 0),            7'd4, 32'h0BADF00D, 0, 0, 32'h0,  32'h0BADF00D);
    add_vec("lb11s",  ld(32'h11, 1, 1),            7'd4, 32'hFFFFFFF0, 0, 0, 32'h0,  32'h0BADF00D);
    add_vec("lh10s",  ld(32'h10, 2, 1),            7'd4, 32'hFFFFF00D, 0, 0, 32'h0,  32'h0BADF00D);
    add_vec("lb13p",  ld(32'h13, 1, 1),            7'd4, 32'h0000000B, 0, 0, 32'h0,  32'h0BADF00D);

    // Reset state.
    #2;
    check_all_zero("reset");
    @(negedge i_clock);
    i_reset = 1'b1;

    // Zero-fill memory through the store path.
    for (int w = 0; w < 128; w++) begin
      drive(st(32'(w * 4), 4, 32'h0), 1'b1, 7'd0);
      tick();
    end
    drive(nop(), 1'b1, 7'd0);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].ins, 1'b1, vecs[i].dbg);
      tick();
      check({vecs[i].name, ".rdata"},  o_MEM_read_data, vecs[i].exp_rd);
      check({vecs[i].name, ".mis"},    32'(o_MEM_misaligned), 32'(vecs[i].exp_mis));
      check({vecs[i].name, ".pc_src"}, 32'(o_MEM_pc_src), 32'(vecs[i].exp_pcsrc));
      check({vecs[i].name, ".baddr"},  o_MEM_branch_addr, vecs[i].exp_baddr);
      check({vecs[i].name, ".fwd"},    o_MEM_fwd_data, vecs[i].ins.alu);
      check({vecs[i].name, ".dbg"},    o_MEM_debug_data, vecs[i].exp_dbg);
    end

    // Enable low: register and memory hold while inputs change.
    drive(ld(32'h10, 4, 0), 1'b1, 7'd8);
    tick();
    r = st(32'h20, 4, 32'h11112222); r.br = 1; r.zr = 1;
    drive(r, 1'b0, 7'd8);
    for (int c = 0; c < 3; c++) tick();
    check("hold.fwd",    o_MEM_fwd_data, 32'h10);
    check("hold.rdata",  o_MEM_read_data, 32'h0BADF00D);
    check("hold.pc_src", 32'(o_MEM_pc_src), 32'h0);
    check("hold.dbg8",   o_MEM_debug_data, 32'h0);

    // Halt: the hlt instruction reaches the outputs, then everything freezes.
    r = nop(); r.hlt = 1; r.rw = 1; r.sel = 5'd5; r.alu = 32'h10; r.pc = 32'h100; r.r31 = 1;
    drive(r, 1'b1, 7'd8);
    tick();
    check("hlt.halted", 32'(o_MEM_halted), 32'h1);
    check("hlt.sel",    32'(o_MEM_selected_reg), 32'h5);
    check("hlt.rw",     32'(o_MEM_reg_write), 32'h1);
    check("hlt.pc",     o_MEM_pc, 32'h100);
    check("hlt.r31",    32'(o_MEM_r31_ctrl), 32'h1);
    drive(st(32'h20, 4, 32'hCAFEF00D), 1'b1, 7'd8);
    tick();
    tick();
    check("hlt.frozen", 32'(o_MEM_halted), 32'h1);
    check("hlt.dbg8",   o_MEM_debug_data, 32'h0);
    check("hlt.fwd",    o_MEM_fwd_data, 32'h10);
    #3;
    i_reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("hltrst");
    @(posedge i_clock);
    #2;
    i_reset = 1'b1;
    drive(nop(), 1'b1, 7'd8);
    tick();
    check("hltrst.halted", 32'(o_MEM_halted), 32'h0);
    check("hltrst.dbg8",   o_MEM_debug_data, 32'h0);

    // Reset asserted between capture and commit of a store discards it.
    drive(st(32'h24, 4, 32'h5555AAAA), 1'b1, 7'd9);
    tick();
    drive(nop(), 1'b1, 7'd9);
    #2;
    i_reset = 1'b0;
    model_reset();
    @(posedge i_clock);
    #2;
    i_reset = 1'b1;
    tick();
    check("rststore.dbg9", o_MEM_debug_data, 32'h0);
    tick();
    check("rststore.dbg9b", o_MEM_debug_data, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      int sz;
      r = nop();
      sz = (n % 3 == 0) ? 1 : ((n % 3 == 1) ? 2 : 4);
      sz = ($urandom_range(0, 2) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 2 : 4);
      r.rd    = ($urandom_range(0, 2) == 0);
      r.wr    = !r.rd && ($urandom_range(0, 1) == 1);
      r.sgn   = 1'($urandom_range(0, 1));
      r.br    = 1'($urandom_range(0, 1));
      r.zr    = 1'($urandom_range(0, 1));
      r.rw    = 1'($urandom_range(0, 1));
      r.m2r   = 1'($urandom_range(0, 1));
      r.r31   = 1'($urandom_range(0, 1));
      r.alu   = ($urandom() & 32'hFFFF_FE00) | 32'($urandom_range(0, 63));
      r.db    = $urandom();
      r.baddr = $urandom();
      r.pc    = $urandom();
      r.sel   = 5'($urandom_range(0, 31));
      r       = with_size(r, sz);
      drive(r, ($urandom_range(0, 7) != 0), 7'($urandom_range(0, 127)));
      tick();
      compare_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
